// File: rtl/server_udp_filter_in.sv
// ---------------------------------------------------------------------------
// server_udp_filter_in
//
// Ingress UDP destination-port filter. Packets arrive on an AXI-Stream style
// input. The first beat carries the IP protocol byte (tdata[191:184]) and the
// second beat carries the UDP destination port (tdata[47:32]). A packet is
// forwarded only if it is UDP (8'h11), at least two beats long, and its port
// equals an enabled entry of the port table. Forwarded packets are written
// whole into a fall-through packet FIFO. Rejected packets are discarded whole.
// Every FIFO beat is tagged with the table index that the packet matched.
//
// Ports:
//   axis_aclk, axis_reset          clock, synchronous active-high reset
//   i_s_tdata/tkeep/tuser          input beat
//   i_s_tvalid, i_s_tlast          input qualifiers
//   o_s_tready                     input ready
//   i_port_table, i_port_en        16-bit port entries and their enables
//   i_fifo_rd_en                   pop one FIFO beat (ignored when empty)
//   o_fifo_empty, o_tvalid         FIFO status (o_tvalid = !o_fifo_empty)
//   o_tdata/tkeep/tuser/tlast      FIFO head beat
//   o_match_idx                    table index of the head beat's packet
//   o_pkt_accept_cnt/o_pkt_drop_cnt packet statistics
//
// Build option:
//   UDP_FILT_STATS_EN  when defined, saturating accept/drop packet counters
//                      are built; otherwise both counters read constant 0.
// ---------------------------------------------------------------------------
module server_udp_filter_in #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 4,
  parameter int FIFO_DEPTH_BITS      = 10,
  localparam int KW   = C_S_AXIS_DATA_WIDTH / 8,
  localparam int IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  i_s_tdata,
  input  logic [KW-1:0]                   i_s_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] i_s_tuser,
  input  logic                            i_s_tvalid,
  input  logic                            i_s_tlast,
  output logic                            o_s_tready,
  input  logic [16*NUM_PORTS-1:0]         i_port_table,
  input  logic [NUM_PORTS-1:0]            i_port_en,
  input  logic                            i_fifo_rd_en,
  output logic                            o_fifo_empty,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]  o_tdata,
  output logic [KW-1:0]                   o_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0] o_tuser,
  output logic                            o_tlast,
  output logic                            o_tvalid,
  output logic [IDXW-1:0]                 o_match_idx,
  output logic [31:0]                     o_pkt_accept_cnt,
  output logic [31:0]                     o_pkt_drop_cnt
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  // Stop accepting once free space drops to two beats: one slot absorbs the
  // beat still sitting in the delay register, one is margin for the header.
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_LIMIT = (FIFO_DEPTH_BITS+1)'(DEPTH - 2);
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE   = (FIFO_DEPTH_BITS+1)'(1);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE   = (FIFO_DEPTH_BITS)'(1);

  typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;

  state_t state_q, state_d;

  // First beat of a candidate packet, held until the port decision is made.
  logic [C_S_AXIS_DATA_WIDTH-1:0]  hdr_data_q;
  logic [KW-1:0]                   hdr_keep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] hdr_user_q;

  // One-beat delay stage: accepted beats reach the FIFO a cycle later.
  logic                            dly_valid_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  dly_data_q;
  logic [KW-1:0]                   dly_keep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] dly_user_q;
  logic                            dly_last_q;
  logic [IDXW-1:0]                 dly_idx_q, dly_idx_d;

  logic [IDXW-1:0] pkt_idx_q, pkt_idx_d;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  mem_data [DEPTH];
  logic [KW-1:0]                   mem_keep [DEPTH];
  logic [C_S_AXIS_TUSER_WIDTH-1:0] mem_user [DEPTH];
  logic                            mem_last [DEPTH];
  logic [IDXW-1:0]                 mem_idx  [DEPTH];

  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_BITS:0]   fifo_count_q;

  logic s_accept, hdr_load, hdr_wr, dly_load;
  logic match_hit;
  logic [IDXW-1:0] match_idx;
  logic fifo_empty, fifo_push, fifo_pop;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  wr_data;
  logic [KW-1:0]                   wr_keep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] wr_user;
  logic                            wr_last;
  logic [IDXW-1:0]                 wr_idx;

  assign fifo_empty = (fifo_count_q == '0);
  assign o_s_tready = !axis_reset && ((state_q == DROP) || (fifo_count_q < CNT_LIMIT));
  assign s_accept   = i_s_tvalid && o_s_tready;
  assign fifo_pop   = i_fifo_rd_en && !fifo_empty;
  assign fifo_push  = hdr_wr || dly_valid_q;

  // Scanning from the top down leaves the lowest matching index last.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int n = NUM_PORTS - 1; n >= 0; n--) begin
      if (i_port_en[n] && (i_port_table[16*n +: 16] == i_s_tdata[47:32])) begin
        match_hit = 1'b1;
        match_idx = IDXW'(n);
      end
    end
  end

  // Packet parser: next state and the header/delay load strobes.
  always_comb begin
    state_d   = state_q;
    hdr_load  = 1'b0;
    hdr_wr    = 1'b0;
    dly_load  = 1'b0;
    pkt_idx_d = pkt_idx_q;
    dly_idx_d = pkt_idx_q;
    case (state_q)
      IDLE: begin
        if (s_accept) begin
          if (!i_s_tlast && (i_s_tdata[191:184] == 8'h11)) begin
            hdr_load = 1'b1;
            state_d  = HDR;
          end else if (!i_s_tlast) begin
            state_d = DROP;
          end
        end
      end
      HDR: begin
        if (s_accept) begin
          if (match_hit) begin
            hdr_wr    = 1'b1;
            dly_load  = 1'b1;
            pkt_idx_d = match_idx;
            dly_idx_d = match_idx;
            state_d   = i_s_tlast ? IDLE : PASS;
          end else begin
            state_d = i_s_tlast ? IDLE : DROP;
          end
        end
      end
      PASS: begin
        if (s_accept) begin
          dly_load = 1'b1;
          if (i_s_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        if (s_accept && i_s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The held header takes the write port in its decision cycle; the delay
  // stage is never occupied in that cycle, so the two never collide.
  always_comb begin
    wr_data = hdr_wr ? hdr_data_q : dly_data_q;
    wr_keep = hdr_wr ? hdr_keep_q : dly_keep_q;
    wr_user = hdr_wr ? hdr_user_q : dly_user_q;
    wr_last = hdr_wr ? 1'b0       : dly_last_q;
    wr_idx  = hdr_wr ? match_idx  : dly_idx_q;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q      <= IDLE;
      hdr_data_q   <= '0;
      hdr_keep_q   <= '0;
      hdr_user_q   <= '0;
      dly_valid_q  <= 1'b0;
      dly_data_q   <= '0;
      dly_keep_q   <= '0;
      dly_user_q   <= '0;
      dly_last_q   <= 1'b0;
      dly_idx_q    <= '0;
      pkt_idx_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pkt_idx_q   <= pkt_idx_d;
      dly_valid_q <= dly_load;
      if (hdr_load) begin
        hdr_data_q <= i_s_tdata;
        hdr_keep_q <= i_s_tkeep;
        hdr_user_q <= i_s_tuser;
      end
      if (dly_load) begin
        dly_data_q <= i_s_tdata;
        dly_keep_q <= i_s_tkeep;
        dly_user_q <= i_s_tuser;
        dly_last_q <= i_s_tlast;
        dly_idx_q  <= dly_idx_d;
      end
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (fifo_push && !fifo_pop)      fifo_count_q <= fifo_count_q + CNT_ONE;
      else if (!fifo_push && fifo_pop) fifo_count_q <= fifo_count_q - CNT_ONE;
    end
  end

  // FIFO storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge axis_aclk) begin
    if (fifo_push) begin
      mem_data[wr_ptr_q] <= wr_data;
      mem_keep[wr_ptr_q] <= wr_keep;
      mem_user[wr_ptr_q] <= wr_user;
      mem_last[wr_ptr_q] <= wr_last;
      mem_idx[wr_ptr_q]  <= wr_idx;
    end
  end

  assign o_fifo_empty = fifo_empty;
  assign o_tvalid     = !fifo_empty;
  assign o_tdata      = mem_data[rd_ptr_q];
  assign o_tkeep      = mem_keep[rd_ptr_q];
  assign o_tuser      = mem_user[rd_ptr_q];
  assign o_tlast      = mem_last[rd_ptr_q];
  assign o_match_idx  = fifo_empty ? '0 : mem_idx[rd_ptr_q];

`ifdef UDP_FILT_STATS_EN
  logic [31:0] acc_cnt_q, drop_cnt_q;
  logic        acc_evt, drop_evt;

  // A packet counts as accepted when its last beat lands in the FIFO, and as
  // dropped when its last beat is consumed without ever being written.
  assign acc_evt  = fifo_push && wr_last;
  assign drop_evt = s_accept && i_s_tlast &&
                    ((state_q == IDLE) || (state_q == DROP) ||
                     ((state_q == HDR) && !match_hit));

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (acc_evt && (acc_cnt_q != 32'hFFFF_FFFF))   acc_cnt_q  <= acc_cnt_q + 32'd1;
      if (drop_evt && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign o_pkt_accept_cnt = acc_cnt_q;
  assign o_pkt_drop_cnt   = drop_cnt_q;
`else
  assign o_pkt_accept_cnt = 32'd0;
  assign o_pkt_drop_cnt   = 32'd0;
`endif

endmodule

// File: doc/server_udp_filter_in.md
SERVER_UDP_FILTER_IN -- requirements
Module: server_udp_filter_in

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, meaning stream data width (>=256).
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, meaning sideband width.
REQ-003 SHALL have parameter NUM_PORTS, default 4, meaning destination-port table entries (1..16).
REQ-004 SHALL have parameter FIFO_DEPTH_BITS, default 10, meaning log2 of packet FIFO depth in beats.
REQ-005 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-006 SHALL have these ports, in this order:
- axis_aclk  in  1  clock
- axis_reset  in  1  synchronous active-high reset
- i_s_tdata/i_s_tkeep/i_s_tuser  in  DW/DW/8/TW  input beat
- i_s_tvalid, i_s_tlast  in  1  input qualifiers
- o_s_tready  out  1  input ready
- i_port_table  in  16*NUM_PORTS  entry n at bits [16n+15:16n]
- i_port_en  in  NUM_PORTS  per-entry enable
- i_fifo_rd_en  in  1  pop one FIFO beat
- o_fifo_empty  out  1  FIFO empty
- o_tdata/o_tkeep/o_tuser/o_tlast  out  DW/DW/8/TW/1  FIFO head (fall-through)
- o_tvalid  out  1  equals !o_fifo_empty
- o_match_idx  out  clog2(NUM_PORTS) (min 1)  table index matched by the head beat's packet
- o_pkt_accept_cnt, o_pkt_drop_cnt  out  32  statistics

Function
REQ-007 A beat SHALL be accepted when i_s_tvalid && o_s_tready.
REQ-008 States SHALL be IDLE, HDR, PASS, DROP.
REQ-009 IDLE: on an accepted beat with tlast=0 and tdata[191:184]==8'h11, the beat SHALL be held in a header register and the state SHALL go to HDR; any other accepted beat SHALL go to DROP (stay IDLE if that beat has tlast=1).
REQ-010 HDR: on an accepted beat, tdata[47:32] SHALL be compared against every enabled entry; lowest matching index wins.
REQ-011 On a match, the held header SHALL be written that cycle, the second beat one cycle later, and the state SHALL go to PASS (IDLE if second beat tlast=1).
REQ-012 On no match in HDR, nothing SHALL be written, and the state SHALL go to DROP (IDLE if tlast=1).
REQ-013 PASS: each accepted beat SHALL be written to the FIFO exactly one cycle after acceptance; tlast=1 SHALL return to IDLE.
REQ-014 DROP: o_s_tready SHALL be 1; beats SHALL be discarded until tlast=1, then the state SHALL go to IDLE.
REQ-015 In IDLE/HDR/PASS, o_s_tready SHALL be deasserted when FIFO free space <= 2 beats.
- This covers the one write in flight.
- No FIFO overflow SHALL be possible.
REQ-016 The packet's match index SHALL be stored with every beat; o_match_idx SHALL reflect the head beat.
REQ-017 A read with o_fifo_empty=1 SHALL be ignored.
- A simultaneous read and write SHALL keep the occupancy unchanged.
REQ-018 A packet SHALL either be written complete with tlast, or not written at all.
REQ-019 i_port_table/i_port_en SHALL be sampled only in the HDR compare cycle.

Reset
REQ-020 While axis_reset=1: state SHALL be IDLE, the FIFO SHALL be empty, the header/delay registers SHALL be cleared, and o_s_tready=0.
- Outputs: o_fifo_empty=1, o_tvalid=0, o_match_idx=0, counters=0.
REQ-021 Reset mid-packet SHALL discard the partial packet.
- The next beat after reset SHALL be treated as a packet start.

Configuration
REQ-022 Macro UDP_FILT_STATS_EN defined: o_pkt_accept_cnt SHALL increment on each completed written packet.
- o_pkt_drop_cnt SHALL increment on each packet ending in DROP or rejected in IDLE/HDR.
- Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-023 Macro undefined: both counters SHALL be constant 0, and no counter logic SHALL be synthesised.

Verification
REQ-024 UDP packet, proto 8'h11, dst port 0x1F90, table[2]=0x1F90 enabled, 4 beats -> 4 beats in FIFO, last has tlast, o_match_idx=2, accept_cnt=1.
REQ-025 TCP packet (proto 8'h06), 3 beats -> FIFO stays empty; tready stays 1; drop_cnt=1.
REQ-026 UDP, port 0x1F90 matches table[1] but i_port_en[1]=0, no other match -> dropped; then next matching packet is accepted intact.
REQ-027 Single-beat packet (tlast on first beat) with proto 8'h11 -> dropped, state IDLE next cycle; 2-beat matching packet -> exactly 2 beats written.
REQ-028 FIFO_DEPTH_BITS=4, no reads, stream 20 matching beats -> tready falls at 14 beats stored; no overflow; after reads, remaining beats are written in order.
REQ-029 Assert axis_reset during PASS beat 3 of 6 -> FIFO empty; next packet is parsed from IDLE and accepted correctly.
